// File: rtl/text_tile_renderer_pkg.sv
// Shared constants for the text tile renderer: glyph codes and render latency.
package text_tile_pkg;
   localparam logic [3:0] GLYPH_B     = 4'd10;
   localparam logic [3:0] GLYPH_F     = 4'd11;
   localparam logic [3:0] GLYPH_I     = 4'd12;
   localparam logic [3:0] GLYPH_Z     = 4'd13;
   localparam logic [3:0] GLYPH_BLANK = 4'd15;
   localparam int         PIPE_LAT    = 3;
endpackage

// File: rtl/text_tile_renderer_if.sv
// Raster in/out, cell write port and clear control of the text tile renderer.
interface text_tile_renderer_if #(
   parameter int XY_W = 10,
   parameter int AW   = 6
);
   logic [XY_W-1:0] px, py;
   logic            active_in, hsync_in, vsync_in;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [3:0]      wdata;
   logic            clear_req;
   logic            busy, pix_on, active_out, hsync_out, vsync_out;

   modport slave (
      input  px, py, active_in, hsync_in, vsync_in, we, waddr, wdata, clear_req,
      output busy, pix_on, active_out, hsync_out, vsync_out
   );
   modport master (
      output px, py, active_in, hsync_in, vsync_in, we, waddr, wdata, clear_req,
      input  busy, pix_on, active_out, hsync_out, vsync_out
   );
endinterface

// File: rtl/text_tile_renderer_glyph_rom.sv
// Combinational 8x8 font: digits, B, F, i, z. Top row is the MSB byte, bit 7 leftmost.
module glyph_rom_8x8
   import text_tile_pkg::*;
(
   input  logic [3:0] code,
   input  logic [2:0] row,
   output logic [7:0] bits
);
   logic [63:0] glyph;

   always_comb begin
      case (code)
         4'd0:    glyph = 64'h7CC6_CEDE_F6E6_7C00;
         4'd1:    glyph = 64'h3070_3030_3030_FC00;
         4'd2:    glyph = 64'h78CC_0C38_60CC_FC00;
         4'd3:    glyph = 64'h78CC_0C38_0CCC_7800;
         4'd4:    glyph = 64'h1C3C_6CCC_FE0C_1E00;
         4'd5:    glyph = 64'hFCC0_F80C_0CCC_7800;
         4'd6:    glyph = 64'h3860_C0F8_CCCC_7800;
         4'd7:    glyph = 64'hFCCC_0C18_3030_3000;
         4'd8:    glyph = 64'h78CC_CC78_CCCC_7800;
         4'd9:    glyph = 64'h78CC_CC7C_0C18_7000;
         GLYPH_B: glyph = 64'hFC66_667C_6666_FC00;
         GLYPH_F: glyph = 64'hFE62_6878_6860_F000;
         GLYPH_I: glyph = 64'h3000_7030_3030_7800;
         GLYPH_Z: glyph = 64'h0000_FC98_3064_FC00;
         default: glyph = 64'h0;
      endcase
      bits = glyph[{3'd7 - row, 3'b000} +: 8];
   end
endmodule

// File: rtl/text_tile_renderer.sv
// Text-mode renderer: COLS x ROWS glyph buffer with self-clear FSM and a
// 3-stage raster-to-pixel pipeline.
module text_tile_renderer
   import text_tile_pkg::*;
#(
   parameter int COLS       = 16,
   parameter int ROWS       = 4,
   parameter int SCALE_LOG2 = 2,
   parameter int X0         = 64,
   parameter int Y0         = 48,
   parameter int XY_W       = 10,
   parameter int AW         = $clog2(COLS*ROWS)
)(
   input logic clk,
   input logic reset,
   text_tile_renderer_if.slave bus
);
   localparam int NCELLS = COLS * ROWS;
   localparam int SH     = 3 + SCALE_LOG2;
   localparam int WIN_W  = COLS << SH;
   localparam int WIN_H  = ROWS << SH;
   localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic signed [XY_W:0] X0_S = (XY_W+1)'(X0);
   localparam logic signed [XY_W:0] Y0_S = (XY_W+1)'(Y0);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          cell_we;
   logic [AW-1:0] cell_wa;
   logic [3:0]    cell_wd;
   logic [3:0]    cells_q [NCELLS];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cell_we = 1'b0;
      cell_wa = bus.waddr;
      cell_wd = bus.wdata;
      if (state_q == ST_CLEAR) begin
         cell_we = 1'b1;
         cell_wa = ptr_q;
         cell_wd = GLYPH_BLANK;
         ptr_d   = ptr_q + AW'(1);
         if (int'(ptr_q) == NCELLS - 1) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      end else if (bus.clear_req) begin
         // clear takes priority; a coincident write is dropped
         state_d = ST_CLEAR;
         ptr_d   = '0;
      end else if (bus.we && int'(bus.waddr) < NCELLS) begin
         cell_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (cell_we) cells_q[cell_wa] <= cell_wd;
   end

   assign bus.busy = (state_q == ST_CLEAR);

   // render pipeline; sync_q carries {active, hsync, vsync} per stage
   logic [PIPE_LAT-1:0][2:0] sync_q, sync_d;
   logic [CW-1:0] col1_q, col1_d;
   logic [RW-1:0] row1_q, row1_d;
   logic [2:0]    gx1_q, gx1_d, gy1_q, gy1_d, gx2_q, gx2_d;
   logic          inwin1_q, inwin1_d, inwin2_q, inwin2_d, pix_q, pix_d;
   logic [7:0]    rowbits2_q, rowbits2_d;
   logic signed [XY_W:0] dx, dy;
   logic [3:0]    rd_code;
   int            rd_idx;

   glyph_rom_8x8 u_rom (.code(rd_code), .row(gy1_q), .bits(rowbits2_d));

   always_comb begin
      dx       = $signed({1'b0, bus.px}) - X0_S;
      dy       = $signed({1'b0, bus.py}) - Y0_S;
      inwin1_d = !dx[XY_W] && !dy[XY_W] &&
                 (int'(dx[XY_W-1:0]) < WIN_W) && (int'(dy[XY_W-1:0]) < WIN_H);
      col1_d   = CW'(dx[XY_W-1:0] >> SH);
      row1_d   = RW'(dy[XY_W-1:0] >> SH);
      gx1_d    = 3'(dx[XY_W-1:0] >> SCALE_LOG2);
      gy1_d    = 3'(dy[XY_W-1:0] >> SCALE_LOG2);
      sync_d   = {sync_q[PIPE_LAT-2:0], {bus.active_in, bus.hsync_in, bus.vsync_in}};

      rd_idx   = int'(row1_q) * COLS + int'(col1_q);
      rd_code  = (inwin1_q && rd_idx < NCELLS) ? cells_q[rd_idx[AW-1:0]] : GLYPH_BLANK;
      gx2_d    = gx1_q;
      inwin2_d = inwin1_q;

      pix_d    = inwin2_q & sync_q[1][2] & rowbits2_q[3'd7 - gx2_q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= '0;
         col1_q     <= '0;
         row1_q     <= '0;
         gx1_q      <= '0;
         gy1_q      <= '0;
         inwin1_q   <= 1'b0;
         rowbits2_q <= '0;
         gx2_q      <= '0;
         inwin2_q   <= 1'b0;
         pix_q      <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         col1_q     <= col1_d;
         row1_q     <= row1_d;
         gx1_q      <= gx1_d;
         gy1_q      <= gy1_d;
         inwin1_q   <= inwin1_d;
         rowbits2_q <= rowbits2_d;
         gx2_q      <= gx2_d;
         inwin2_q   <= inwin2_d;
         pix_q      <= pix_d;
      end
   end

   assign bus.pix_on     = pix_q;
   assign bus.active_out = sync_q[PIPE_LAT-1][2];
   assign bus.hsync_out  = sync_q[PIPE_LAT-1][1];
   assign bus.vsync_out  = sync_q[PIPE_LAT-1][0];
endmodule

// File: tb/tb_text_tile_renderer.sv
// Scoreboard bench for text_tile_renderer: expectations queued at drive time,
// compared 3 clocks later; busy durations counted directly.
module tb_text_tile_renderer;
   import text_tile_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   text_tile_renderer_if #(.XY_W(10), .AW(6)) bus ();

   text_tile_renderer #(
      .COLS(16), .ROWS(4), .SCALE_LOG2(2), .X0(64), .Y0(48), .XY_W(10), .AW(6)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct packed {
      logic chk;
      logic pix;
      logic a;
      logic h;
      logic v;
   } exp_t;

   exp_t        sbq[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [3:0]  mcell [64];
   logic [63:0] font [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      n_vec++;
      if (got !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp_v, $time);
      end
   endtask

   function automatic logic model_pix(input int x, input int y, input logic a);
      int dx, dy;
      logic [63:0] g;
      logic [7:0]  b;
      dx = x - 64;
      dy = y - 48;
      if (!a || dx < 0 || dy < 0 || dx >= 512 || dy >= 128) return 1'b0;
      g = font[mcell[(dy / 32) * 16 + dx / 32]];
      b = 8'(g >> (8 * (7 - (dy / 4) % 8)));
      return b[7 - (dx / 4) % 8];
   endfunction

   task automatic cyc(input int x, input int y, input logic a, input logic h, input logic v,
                      input logic we, input int wa, input int wd, input logic clr,
                      input logic chk_pix);
      exp_t e;
      @(posedge clk);
      #1;
      if (sbq.size() >= 3) begin
         e = sbq.pop_front();
         check("active_out", bus.active_out, e.a);
         check("hsync_out", bus.hsync_out, e.h);
         check("vsync_out", bus.vsync_out, e.v);
         if (e.chk) check("pix_on", bus.pix_on, e.pix);
      end
      bus.px = 10'(x);
      bus.py = 10'(y);
      bus.active_in = a;
      bus.hsync_in = h;
      bus.vsync_in = v;
      bus.we = we;
      bus.waddr = 6'(wa);
      bus.wdata = 4'(wd);
      bus.clear_req = clr;
      sbq.push_back('{chk: chk_pix, pix: model_pix(x, y, a), a: a, h: h, v: v});
   endtask

   task automatic tick();
      cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic pix(input int x, input int y, input logic a);
      cyc(x, y, a, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 300) begin
         n++;
         tick();
      end
   endtask

   task automatic do_reset(input int hold);
      reset = 1'b1;
      bus.px = 10'd80; bus.py = 10'd60;
      bus.active_in = 1'b1; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
      bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.clear_req = 1'b0;
      repeat (hold) @(posedge clk);
      #1;
      check("rst pix_on", bus.pix_on, 1'b0);
      check("rst active_out", bus.active_out, 1'b0);
      check("rst hsync_out", bus.hsync_out, 1'b0);
      check("rst vsync_out", bus.vsync_out, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.active_in = 1'b0; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
      sbq.delete();
      for (int i = 0; i < 64; i++) mcell[i] = GLYPH_BLANK;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int x, y, wa, wd;
      font[0]  = 64'h7CC6CEDEF6E67C00; font[1]  = 64'h307030303030FC00;
      font[2]  = 64'h78CC0C3860CCFC00; font[3]  = 64'h78CC0C380CCC7800;
      font[4]  = 64'h1C3C6CCCFE0C1E00; font[5]  = 64'hFCC0F80C0CCC7800;
      font[6]  = 64'h3860C0F8CCCC7800; font[7]  = 64'hFCCC0C1830303000;
      font[8]  = 64'h78CCCC78CCCC7800; font[9]  = 64'h78CCCC7C0C187000;
      font[10] = 64'hFC66667C6666FC00; font[11] = 64'hFE6268786860F000;
      font[12] = 64'h3000703030307800; font[13] = 64'h0000FC983064FC00;
      font[14] = 64'h0;                font[15] = 64'h0;

      // reset and power-up clear
      do_reset(3);
      count_busy(n);
      check("busy after reset", n, 64);
      for (int yy = 48; yy < 176; yy += 4)
         for (int xx = 64; xx < 576; xx += 3)
            pix(xx, yy, 1'b1);

      // glyph '1' in cell 0
      mcell[0] = 4'd1;
      cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
      pix(72, 48, 1'b1);
      pix(64, 48, 1'b1);
      pix(72, 52, 1'b1);

      // window edges and active gating with '8' in cell 63
      mcell[63] = 4'd8;
      cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 63, 8, 1'b0, 1'b0);
      pix(544, 148, 1'b1);
      pix(576, 48, 1'b1);
      pix(544, 148, 1'b0);
      pix(63, 48, 1'b1);
      pix(575, 175, 1'b1);
      pix(64, 176, 1'b1);

      // random writes and pixels with toggling syncs
      for (int i = 0; i < 1500; i++) begin
         x = $urandom_range(620, 40);
         y = $urandom_range(200, 30);
         if ($urandom_range(4, 0) == 0) begin
            wa = $urandom_range(63, 0);
            wd = $urandom_range(15, 0);
            mcell[wa] = 4'(wd);
            cyc(x, y, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, wa, wd, 1'b0, 1'b1);
         end else begin
            cyc(x, y, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 0, 0, 1'b0, 1'b1);
         end
      end

      // clear with coincident write; writes and clear_req during busy ignored
      cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 9, 1'b1, 1'b0);
      for (int i = 0; i < 64; i++) mcell[i] = GLYPH_BLANK;
      tick();
      n = 0;
      while (bus.busy === 1'b1 && n < 300) begin
         n++;
         if (n == 40) cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 8, 1'b1, 1'b0);
         else tick();
      end
      check("busy after clear_req", n, 64);
      for (int yy = 48; yy < 80; yy += 2) begin
         for (int xx = 160; xx < 192; xx += 2) pix(xx, yy, 1'b1);
         for (int xx = 224; xx < 256; xx += 2) pix(xx, yy, 1'b1);
      end

      // write after clear is visible again
      mcell[5] = 4'd0;
      cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 0, 1'b0, 1'b0);
      for (int xx = 224; xx < 256; xx += 1) pix(xx, 52, 1'b1);

      // reset in the middle of a clear
      cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      repeat (20) tick();
      check("busy mid clear", bus.busy, 1'b1);
      do_reset(2);
      count_busy(n);
      check("busy after mid-clear reset", n, 64);
      pix(72, 48, 1'b1);
      pix(232, 52, 1'b1);
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
